// File: rtl/modn_down_counter.sv
// modn_down_counter: programmable modulo-N down counter with shadowed modulus, terminal count and wrap pulse
module modn_down_counter #(
    parameter int WIDTH = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] modN,
    output logic [WIDTH-1:0] count,
    output logic [WIDTH-1:0] active_mod,
    output logic             tc,
    output logic             wrap,
    output logic             busy
);
    typedef enum logic {IDLE, RUN} state_t;
    state_t state;
    logic valid;
    assign valid = modN >= WIDTH'(2);
    assign busy = state == RUN;
    assign tc = busy && count == '0;
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            count      <= '0;
            active_mod <= '0;
            wrap       <= 1'b0;
        end else begin
            wrap <= 1'b0;
            // Every reload path shares the same adopt-or-drop-to-idle decision on modN validity
            if (state == IDLE || load || (en && count == '0)) begin
                wrap       <= state == RUN && !load;
                state      <= valid ? RUN : IDLE;
                count      <= valid ? modN - WIDTH'(1) : '0;
                active_mod <= valid ? modN : '0;
            end else if (en) begin
                count <= count - WIDTH'(1);
            end
        end
    end
endmodule

// File: tb/tb_modn_down_counter.sv
// tb_modn_down_counter: directed literal checks plus randomized stimulus against a behavioural model
module tb_modn_down_counter;
    logic clk = 0, reset = 1, en = 0, load = 0;
    logic [5:0] modN = 0;
    logic [5:0] count, active_mod;
    logic tc, wrap, busy;
    int total = 0, bad = 0;
    bit m_run = 0, m_wrap = 0;
    int m_cnt = 0, m_mod = 0;

    modn_down_counter #(.WIDTH(6)) dut (
        .clk(clk), .reset(reset), .en(en), .load(load), .modN(modN),
        .count(count), .active_mod(active_mod), .tc(tc), .wrap(wrap), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: the counter walks N-1..0 cyclically; any reload adopts modN if legal, else returns to idle
    task automatic adopt();
        int n;
        n = int'(modN);
        if (n >= 2) begin
            m_run = 1; m_mod = n; m_cnt = n - 1;
        end else begin
            m_run = 0; m_mod = 0; m_cnt = 0;
        end
    endtask

    always @(posedge clk) begin
        if (reset) begin
            m_run = 0; m_cnt = 0; m_mod = 0; m_wrap = 0;
        end else if (!m_run) begin
            m_wrap = 0;
            adopt();
        end else if (load) begin
            m_wrap = 0;
            adopt();
        end else if (en) begin
            m_wrap = (m_cnt == 0);
            if (m_cnt == 0) adopt();
            else m_cnt = (m_cnt + m_mod - 1) % m_mod;
        end else begin
            m_wrap = 0;
        end
    end

    always @(posedge clk) begin
        #1;
        chk("m_count", int'(count), m_cnt);
        chk("m_active_mod", int'(active_mod), m_mod);
        chk("m_busy", int'(busy), int'(m_run));
        chk("m_tc", int'(tc), int'(m_run && m_cnt == 0));
        chk("m_wrap", int'(wrap), int'(m_wrap));
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        tick(); tick();
        chk("rst_count", int'(count), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_tc", int'(tc), 0);
        chk("rst_wrap", int'(wrap), 0);
        chk("rst_mod", int'(active_mod), 0);
        reset = 0; modN = 5; en = 1;
        tick(); chk("n5_first", int'(count), 4); chk("n5_busy", int'(busy), 1);
        tick(); chk("n5_c3", int'(count), 3);
        tick(); chk("n5_c2", int'(count), 2);
        tick(); chk("n5_c1", int'(count), 1);
        tick(); chk("n5_c0", int'(count), 0); chk("n5_tc", int'(tc), 1);
        tick(); chk("n5_reload", int'(count), 4); chk("n5_wrap", int'(wrap), 1);
        modN = 4; load = 1;
        tick(); load = 0;
        chk("ld_count", int'(count), 3); chk("ld_mod", int'(active_mod), 4); chk("ld_wrap", int'(wrap), 0);
        tick(); tick(); tick(); chk("ld_c0", int'(count), 0);
        modN = 3; load = 1;
        tick(); load = 0;
        chk("ldwrap_count", int'(count), 2); chk("ldwrap_nowrap", int'(wrap), 0);
        modN = 1;
        tick(); tick(); chk("inv_c0", int'(count), 0);
        tick(); chk("inv_wrap", int'(wrap), 1); chk("inv_busy", int'(busy), 0); chk("inv_mod", int'(active_mod), 0);
        tick(); chk("inv_idle", int'(busy), 0); chk("inv_wrap_off", int'(wrap), 0);
        modN = 2;
        tick(); chk("n2_c1", int'(count), 1);
        tick(); chk("n2_c0", int'(count), 0); chk("n2_tc", int'(tc), 1);
        tick(); chk("n2_c1b", int'(count), 1); chk("n2_wrap", int'(wrap), 1);
        modN = 63; load = 1;
        tick(); load = 0; chk("n63_first", int'(count), 62);
        repeat (62) tick();
        chk("n63_c0", int'(count), 0);
        tick(); chk("n63_reload", int'(count), 62); chk("n63_wrap", int'(wrap), 1);
        tick(); tick(); en = 0;
        tick(); tick(); chk("hold", int'(count), 60); chk("hold_wrap", int'(wrap), 0);
        en = 1; reset = 1;
        tick(); reset = 0;
        chk("midrst_count", int'(count), 0); chk("midrst_busy", int'(busy), 0);
        for (int i = 0; i < 3000; i++) begin
            reset = ($urandom_range(0, 199) == 0);
            load = ($urandom_range(0, 29) == 0);
            en = ($urandom_range(0, 4) != 0);
            if ($urandom_range(0, 9) == 0)
                modN = ($urandom_range(0, 7) == 0) ? 6'd63 : 6'($urandom_range(0, 12));
            tick();
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
